// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the skid-buffered inter-stage pipeline register.
// The state encoding mirrors the valid bits as {skid_valid, main_valid}.
// The control-field indices name the bits each stage packs into the ctrl payload.
package pipe_stage_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_HALT      = 1;
    localparam int CTRL_JUMP      = 2;
    localparam int CTRL_BR        = 3;
    localparam int CTRL_ALIGN_ERR = 4;

endpackage

// File: rtl/pipe_entry_reg.sv
// One {valid, ctrl, data} entry of the stage.
// The valid bit is rewritten every cycle from next_valid.
// ctrl is forced to zero whenever the entry becomes invalid, so a bubble never carries control bits.
// data only changes on load and is otherwise held, including across bubbles.
module pipe_entry_reg
    import pipe_stage_skid_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              next_valid,
    input  logic [CTRL_W-1:0] wr_ctrl,
    input  logic [DATA_W-1:0] wr_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Valid and ctrl: reset to zero, ctrl cleared whenever the entry goes invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else begin
            valid <= next_valid;
            if (!next_valid) begin
                ctrl <= '0;
            end else if (load) begin
                ctrl <= wr_ctrl;
            end
        end
    end

    // Data: reset to zero, otherwise loaded on demand and held in bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= wr_data;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
//
// Handshake: an input transfer happens on a cycle where in_valid && in_ready.
// An output transfer happens on a cycle where out_valid && out_ready.
// in_ready is the inverse of the registered skid valid bit, so it never depends
// combinationally on out_ready. Once in_valid is raised, upstream holds it and the
// payload until the transfer.
//
// The main entry drives the outputs. The skid entry absorbs the one entry that
// arrives in the cycle downstream stalls. flush drops both entries and leaves a
// bubble with ctrl = 0. stall_cnt counts cycles with out_valid && !out_ready and
// saturates at its maximum value.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_cnt_clr,
    output logic [1:0]        state
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    state_t cur_state;
    state_t nxt_state;

    logic main_load;
    logic main_from_skid;
    logic skid_load;

    // The state register is the pair of valid bits held in the two entries.
    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk        (clk),
        .rst        (rst),
        .load       (main_load),
        .next_valid (nxt_state != ST_EMPTY),
        .wr_ctrl    (main_from_skid ? skid_ctrl : in_ctrl),
        .wr_data    (main_from_skid ? skid_data : in_data),
        .valid      (main_valid),
        .ctrl       (main_ctrl),
        .data       (main_data)
    );

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .next_valid (nxt_state == ST_FULL),
        .wr_ctrl    (in_ctrl),
        .wr_data    (in_data),
        .valid      (skid_valid),
        .ctrl       (skid_ctrl),
        .data       (skid_data)
    );

    // Decode the current state from the registered valid bits.
    always_comb begin
        cur_state = ST_EMPTY;
        if (skid_valid) begin
            cur_state = ST_FULL;
        end else if (main_valid) begin
            cur_state = ST_ONE;
        end
    end

    // Next state. flush wins over the handshake, and in_valid is ignored in FULL.
    always_comb begin
        nxt_state = cur_state;
        if (flush) begin
            nxt_state = ST_EMPTY;
        end else begin
            case (cur_state)
                ST_EMPTY: nxt_state = in_valid ? ST_ONE : ST_EMPTY;
                ST_ONE: begin
                    if (out_ready) begin
                        nxt_state = in_valid ? ST_ONE : ST_EMPTY;
                    end else begin
                        nxt_state = in_valid ? ST_FULL : ST_ONE;
                    end
                end
                ST_FULL:  nxt_state = out_ready ? ST_ONE : ST_FULL;
                default:  nxt_state = ST_EMPTY;
            endcase
        end
    end

    // Entry load controls. Main refills from skid when FULL drains, keeping FIFO order.
    always_comb begin
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (!flush) begin
            case (cur_state)
                ST_EMPTY: main_load = in_valid;
                ST_ONE: begin
                    if (out_ready) begin
                        main_load = in_valid;
                    end else begin
                        skid_load = in_valid;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    main_load = 1'b0;
                end
            endcase
        end
    end

    // Saturating stall counter. A clear beats an increment in the same cycle, and flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_cnt_clr) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Every output is a flop or a plain rename of flops.
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign state     = cur_state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid.
// The reference model is a FIFO queue holding at most two entries, plus a
// saturating counter. Directed scenarios run first, followed by random traffic.
module tb_pipe_stage_skid;
    import pipe_stage_skid_pkg::*;

    localparam int DATA_W  = 16;
    localparam int CTRL_W  = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  stall_cnt;
    logic              stall_cnt_clr;
    logic [1:0]        state;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [DATA_W-1:0] exp_q[$];
    logic [CTRL_W-1:0] exp_ctrl_q[$];
    logic [DATA_W-1:0] exp_last_data = '0;
    int                exp_cnt = 0;

    pipe_stage_skid #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_ctrl       (in_ctrl),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_ctrl      (out_ctrl),
        .stall_cnt     (stall_cnt),
        .stall_cnt_clr (stall_cnt_clr),
        .state         (state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge, using the inputs that were applied during the cycle.
    task automatic model_update();
        bit ov;
        bit rdy;
        ov  = (exp_q.size() > 0);
        rdy = (exp_q.size() < 2);
        if (rst) begin
            exp_q.delete();
            exp_ctrl_q.delete();
            exp_cnt       = 0;
            exp_last_data = '0;
        end else begin
            if (stall_cnt_clr) begin
                exp_cnt = 0;
            end else if (ov && !out_ready && exp_cnt < CNT_MAX) begin
                exp_cnt++;
            end
            if (flush) begin
                exp_q.delete();
                exp_ctrl_q.delete();
            end else begin
                if (ov && out_ready) begin
                    void'(exp_q.pop_front());
                    void'(exp_ctrl_q.pop_front());
                end
                if (in_valid && rdy) begin
                    exp_q.push_back(in_data);
                    exp_ctrl_q.push_back(in_ctrl);
                end
            end
        end
        if (exp_q.size() > 0) begin
            exp_last_data = exp_q[0];
        end
    endtask

    task automatic check_all();
        state_t es;
        es = (exp_q.size() == 0) ? ST_EMPTY : (exp_q.size() == 1) ? ST_ONE : ST_FULL;
        check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
        check("in_ready",  64'(in_ready),  64'(exp_q.size() < 2));
        check("out_ctrl",  64'(out_ctrl),  64'((exp_q.size() > 0) ? exp_ctrl_q[0] : '0));
        check("out_data",  64'(out_data),  64'(exp_last_data));
        check("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
        check("state",     64'(state),     64'(es));
    endtask

    // Drive one cycle of inputs, step the model at the edge, then check on the falling edge.
    task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                        input logic ordy, input logic fl, input logic clr, input logic r);
        in_valid      = iv;
        in_data       = d;
        in_ctrl       = c;
        out_ready     = ordy;
        flush         = fl;
        stall_cnt_clr = clr;
        rst           = r;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    localparam logic [CTRL_W-1:0] C_RW = CTRL_W'(1 << CTRL_REGWRITE);

    initial begin
        // Reset then idle
        step(0, '0, '0, 1, 0, 0, 1);
        step(0, '0, '0, 1, 0, 0, 1);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_stall_cnt", 64'(stall_cnt), 64'(0));
        step(0, '0, '0, 1, 0, 0, 0);

        // Streaming back-to-back
        for (int i = 1; i <= 5; i++) begin
            step(1, DATA_W'(i), C_RW, 1, 0, 0, 0);
            check("stream_data", 64'(out_data), 64'(i));
            check("stream_ready", 64'(in_ready), 64'(1));
        end
        step(0, '0, '0, 1, 0, 0, 0);
        step(0, '0, '0, 1, 0, 0, 1'b1 & 1'b0);

        // Stall with skid: A, B under stall, C ignored, then drain
        step(0, '0, '0, 1, 0, 1, 0);
        step(1, 16'h00A0, 8'h01, 0, 0, 0, 0);
        step(1, 16'h00B0, 8'h02, 0, 0, 0, 0);
        step(1, 16'h00C0, 8'h04, 0, 0, 0, 0);
        step(0, '0, '0, 0, 0, 0, 0);
        check("full_in_ready", 64'(in_ready), 64'(0));
        check("full_hold_a",   64'(out_data), 64'(16'h00A0));
        check("stall_cnt_3",   64'(stall_cnt), 64'(3));
        step(0, '0, '0, 1, 0, 0, 0);
        check("drain_b", 64'(out_data), 64'(16'h00B0));
        step(0, '0, '0, 1, 0, 0, 0);
        check("drain_empty", 64'(out_valid), 64'(0));

        // Flush while FULL, offering a ctrl = 0xFF entry in the flush cycle
        step(1, 16'h0111, 8'h11, 0, 0, 0, 0);
        step(1, 16'h0222, 8'h22, 0, 0, 0, 0);
        step(1, 16'h0333, 8'hFF, 0, 1, 0, 0);
        check("flush_valid", 64'(out_valid), 64'(0));
        check("flush_ctrl",  64'(out_ctrl),  64'(0));
        check("flush_ready", 64'(in_ready),  64'(1));
        step(0, '0, '0, 1, 0, 0, 0);
        check("flush_no_capture", 64'(out_valid), 64'(0));

        // Counter saturation, then a clear that coincides with a stall
        step(1, 16'h0444, 8'h08, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) step(0, '0, '0, 0, 0, 0, 0);
        check("cnt_saturate", 64'(stall_cnt), 64'(15));
        step(0, '0, '0, 0, 0, 1, 0);
        check("cnt_clr_prio", 64'(stall_cnt), 64'(0));

        // Reset while stalled in FULL
        step(1, 16'h0555, 8'h10, 0, 0, 0, 0);
        check("pre_rst_full", 64'(in_ready), 64'(0));
        step(0, '0, '0, 0, 0, 0, 1);
        check("midrst_valid", 64'(out_valid), 64'(0));
        check("midrst_ready", 64'(in_ready),  64'(1));
        check("midrst_data",  64'(out_data),  64'(0));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), DATA_W'($urandom), CTRL_W'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 149) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
